mem_access_ctrl: RTL and testbench
==================================

# mem_access_ctrl

Requester-side controller for the single-port word memory: accepts one load or store at a time from the CPU datapath over a valid/ready handshake, converts the byte address to a word index, drives the memory's `memRead`/`memWrite` strobes for exactly one cycle, and captures the memory's registered read data. It returns a response with data and an error flag, holding it until the datapath accepts it. It sits between the multicycle datapath and the memory block.

## Interface
- `MEM_WORDS`, default 200: number of words in the attached memory. Used only by the bounds check.
- `clk` in 1: the single clock. Everything is sampled on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: the controller can accept a request.
- `req_write` in 1: 1 for a store, 0 for a load.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data.
- `resp_valid` out 1: response present.
- `resp_ready` in 1: the datapath accepts the response.
- `resp_rdata` out 32: load data. It is 0 for stores and for errors.
- `resp_err` out 1: the access was rejected and no memory strobe was issued.
- `memAdress` out 32: word index sent to the memory.
- `memData` out 32: write data sent to the memory.
- `memRead` out 1: memory read strobe.
- `memWrite` out 1: memory write strobe.
- `memOut` in 32: read data from the memory. It updates on the same edge that samples `memRead`.

## Operation
- The states are IDLE, ISSUE, CAPTURE and DONE. The state register is reset asynchronously to IDLE.
- **IDLE**
  - `req_ready`=1.
  - A handshake occurs when `req_valid`&&`req_ready`. It latches `req_write`, `req_addr` and `req_wdata`.
  - A valid request goes to ISSUE.
  - A rejected request goes straight to DONE with the error flag set.
- **ISSUE** (exactly one cycle)
  - `memAdress` = `addr_q`>>2.
  - `memData` = `wdata_q`.
  - `memWrite` = `write_q` and `memRead` = !`write_q`.
  - A store goes to DONE. A load goes to CAPTURE.
- **CAPTURE** (one cycle): `memOut` is valid. Latch it into `rdata_q` and go to DONE.
- **DONE**
  - `resp_valid`=1, `resp_rdata`=`rdata_q`, `resp_err`=`err_q`.
  - Hold these until `resp_ready`=1, then return to IDLE.
- Rejection rules:
  - `req_addr[1:0]`≠0 (misaligned) always gives an error.
  - The out-of-range check is described under Configuration.
- Strobes and `req_ready` are decoded from the state register only. The two strobes are never high together, and each is never high for more than one cycle per request.
- `memAdress`/`memData` are 0 outside ISSUE.
- `rdata_q` is cleared on every accept, so stores and errors return 0.
- A new request is accepted only in IDLE. Back-to-back requests therefore need one IDLE cycle between them.

## Timing
- Reset values:
  - `req_ready`=0 while `reset` is high.
  - `resp_valid`=0, `resp_rdata`=0, `resp_err`=0.
  - `memRead`=`memWrite`=0, `memAdress`=0, `memData`=0.
  - `req_ready` rises in the first cycle after `reset` deasserts.
- Latency is counted from the accept edge E. The counts assume `resp_ready`=1.
  - Load: ISSUE in E+1, CAPTURE in E+2, `resp_valid` in E+3, IDLE in E+4.
  - Store: ISSUE in E+1, `resp_valid` in E+2, IDLE in E+3.
  - Error: `resp_valid` in E+1, with no strobe.
- Backpressure: DONE holds indefinitely and all response outputs stay stable.
- Reset mid-operation: all state is cleared immediately, even in ISSUE, so strobes drop asynchronously. The pending request is discarded and no response is produced.
- `req_valid` during a non-IDLE state is ignored. It is not queued.

## Configuration
- `MEM_BOUNDS_CHECK_EN` defined:
  - A word index ≥ `MEM_WORDS` is rejected.
  - A rejected request goes to DONE with `resp_err`=1 and issues no strobe.
- `MEM_BOUNDS_CHECK_EN` undefined:
  - Out-of-range indices are passed to the memory unchanged.
  - Only misalignment sets `resp_err`.
  - The `MEM_WORDS` parameter is unused.

## Structure
- Shared package `cpmath_mem_pkg` contains:
  - the state enum: IDLE, ISSUE, CAPTURE, DONE;
  - `MEM_WORDS_DEFAULT` = 200;
  - `WORD_SHIFT` = 2.
- One sub-module, `mem_addr_check`: combinational. It takes the byte address and outputs the word index and a `reject` flag. The bounds compare is inside the macro guard.

## Test plan
- Store `req_addr`=0x1A4, `req_wdata`=5, then load 0x1A4:
  - Store: `memWrite` high for one cycle with `memAdress`=105 and `memData`=5.
  - Load: `memRead` high for one cycle at 105; `resp_rdata`=5 exactly 3 cycles after accept; `resp_err`=0.
- Load 0x1A4 with `resp_ready` held 0 for 5 cycles: `resp_valid` and `resp_rdata` stay stable, the next request is not accepted, and the response completes on the first `resp_ready`=1.
- Misaligned store at 0x1A6: `resp_err`=1 one cycle after accept, `resp_rdata`=0, and `memWrite` never asserts.
- Load at 0x320 (word 200):
  - With `MEM_BOUNDS_CHECK_EN`: `resp_err`=1 and no `memRead`.
  - Without the macro: `memRead` at index 200 and `resp_err`=0.
- Assert `reset` during the ISSUE cycle of a store:
  - `memWrite` drops immediately and no `resp_valid` appears.
  - `req_ready`=1 one cycle after reset release.
- Load directly followed by store, with `req_valid` held high:
  - The store is accepted only in IDLE after the load response.
  - The strobes never overlap.

Source files
------------

// File: rtl/cpmath_mem_pkg.sv
// Shared definitions for the requester-side memory access controller.
//   state_t           : controller FSM states (IDLE, ISSUE, CAPTURE, DONE)
//   MEM_WORDS_DEFAULT : default word count of the attached memory
//   WORD_SHIFT        : byte-address to word-index shift (32-bit words)
package cpmath_mem_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam int MEM_WORDS_DEFAULT = 200;
  localparam int WORD_SHIFT        = 2;

endpackage

// File: rtl/mem_addr_check.sv
// Combinational address check for the memory access controller.
// Converts a byte address into a word index and flags requests that must
// not reach the memory.
// Optional feature macro: MEM_BOUNDS_CHECK_EN (adds word index >= MEM_WORDS
// rejection; without it only misalignment is rejected).
// Ports:
//   addr     in  32 : byte address of the request
//   word_idx out 32 : addr >> WORD_SHIFT
//   reject   out 1  : request is misaligned (or out of range when enabled)
module mem_addr_check
  import cpmath_mem_pkg::*;
#(
  parameter int MEM_WORDS = MEM_WORDS_DEFAULT
) (
  input  logic [31:0] addr,
  output logic [31:0] word_idx,
  output logic        reject
);

  logic misaligned;

  assign word_idx   = addr >> WORD_SHIFT;
  assign misaligned = |addr[WORD_SHIFT-1:0];

`ifdef MEM_BOUNDS_CHECK_EN
  logic out_of_range;

  assign out_of_range = (word_idx >= 32'(MEM_WORDS));
  assign reject       = misaligned | out_of_range;
`else
  // The word count only matters for the bounds compare; keep it referenced.
  logic [31:0] unused_mem_words;

  assign unused_mem_words = 32'(MEM_WORDS);
  assign reject           = misaligned;
`endif

endmodule

// File: rtl/mem_access_ctrl.sv
// Requester-side controller for the single-port word memory.
// Accepts one load/store at a time over valid/ready, issues a one-cycle
// memRead/memWrite strobe, captures the registered read data and holds a
// response (data + error flag) until the datapath accepts it.
// Optional feature macro: MEM_BOUNDS_CHECK_EN (see mem_addr_check).
// Ports:
//   clk, reset                  : clock, asynchronous active-high reset
//   req_valid/req_ready         : request handshake
//   req_write, req_addr,
//   req_wdata                   : store flag, byte address, store data
//   resp_valid/resp_ready       : response handshake
//   resp_rdata, resp_err        : load data (0 for stores/errors), reject flag
//   memAdress, memData          : word index and write data to the memory
//   memRead, memWrite           : one-cycle memory strobes
//   memOut                      : registered read data from the memory
module mem_access_ctrl
  import cpmath_mem_pkg::*;
#(
  parameter int MEM_WORDS = MEM_WORDS_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] memAdress,
  output logic [31:0] memData,
  output logic        memRead,
  output logic        memWrite,
  input  logic [31:0] memOut
);

  state_t      state;
  logic        ready_en;
  logic        accept;
  logic [31:0] word_idx;
  logic        reject;

  logic        write_q;
  logic        err_q;
  logic [31:0] idx_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;

  mem_addr_check #(
    .MEM_WORDS (MEM_WORDS)
  ) u_addr_check (
    .addr     (req_addr),
    .word_idx (word_idx),
    .reject   (reject)
  );

  assign accept = req_valid && req_ready;

  // ready_en keeps req_ready low until the first clock after reset release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      case (state)
        IDLE:    if (accept) state <= reject ? DONE : ISSUE;
        ISSUE:   state <= write_q ? DONE : CAPTURE;
        CAPTURE: state <= DONE;
        DONE:    if (resp_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Request/response payload; only observed through state-gated outputs,
  // so it carries no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      write_q <= req_write;
      err_q   <= reject;
      idx_q   <= word_idx;
      wdata_q <= req_wdata;
      rdata_q <= '0;
    end else if (state == CAPTURE) begin
      rdata_q <= memOut;
    end
  end

  // All outputs decode from the state register, so reset drops them at once.
  assign req_ready  = (state == IDLE) && ready_en;
  assign resp_valid = (state == DONE);
  assign resp_rdata = resp_valid ? rdata_q : '0;
  assign resp_err   = resp_valid && err_q;
  assign memRead    = (state == ISSUE) && !write_q;
  assign memWrite   = (state == ISSUE) && write_q;
  assign memAdress  = (state == ISSUE) ? idx_q   : '0;
  assign memData    = (state == ISSUE) ? wdata_q : '0;

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] memAdress;
  logic [31:0] memData;
  logic        memRead;
  logic        memWrite;
  logic [31:0] memOut;

  int errors = 0;
  int checks = 0;

  int wr_cnt = 0;
  int rd_cnt = 0;
  int overlap_cnt = 0;

  logic [31:0] mem [0:255];

  mem_access_ctrl #(.MEM_WORDS(200)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .memAdress  (memAdress),
    .memData    (memData),
    .memRead    (memRead),
    .memWrite   (memWrite),
    .memOut     (memOut)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory model: registered read, data updates on the edge sampling memRead.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
      memOut <= '0;
    end else begin
      if (memWrite) mem[memAdress[7:0]] <= memData;
      if (memRead)  memOut <= mem[memAdress[7:0]];
    end
  end

  // Strobe monitor.
  always @(posedge clk) begin
    if (memWrite) wr_cnt <= wr_cnt + 1;
    if (memRead)  rd_cnt <= rd_cnt + 1;
    if (memRead && memWrite) overlap_cnt <= overlap_cnt + 1;
  end

  // Call at a negedge. Returns at the negedge after the accept edge (ISSUE cycle).
  task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d,
                      output bit ok);
    int n;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    ok = req_ready;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready got=%b want=0", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got=%b want=0", resp_valid); end
    checks++; if (resp_rdata !== 32'd0) begin errors++; $display("FAIL reset_resp_rdata got=%h want=0", resp_rdata); end
    checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL reset_resp_err got=%b want=0", resp_err); end
    checks++; if ({memRead, memWrite} !== 2'b00) begin errors++; $display("FAIL reset_strobes got=%b want=00", {memRead, memWrite}); end
    checks++; if (memAdress !== 32'd0 || memData !== 32'd0) begin errors++; $display("FAIL reset_mem_bus got=%h/%h want=0/0", memAdress, memData); end
    reset = 1'b0;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got=%b want=1", req_ready); end
  endtask

  task automatic test_store_load();
    bit ok;
    send(1'b1, 32'h1A4, 32'd5, ok);
    checks++; if (!ok) begin errors++; $display("FAIL sl_store_accept got=0 want=1"); end
    checks++; if (memWrite !== 1'b1 || memRead !== 1'b0) begin errors++; $display("FAIL sl_store_strobe got=%b%b want=01", memRead, memWrite); end
    checks++; if (memAdress !== 32'd105) begin errors++; $display("FAIL sl_store_addr got=%0d want=105", memAdress); end
    checks++; if (memData !== 32'd5) begin errors++; $display("FAIL sl_store_data got=%0d want=5", memData); end
    @(negedge clk);
    checks++; if (memWrite !== 1'b0) begin errors++; $display("FAIL sl_store_one_cycle got=%b want=0", memWrite); end
    checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b0 || resp_rdata !== 32'd0)
      begin errors++; $display("FAIL sl_store_resp got=v%b e%b d%h want=v1 e0 d0", resp_valid, resp_err, resp_rdata); end
    @(negedge clk);
    checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL sl_store_idle got=v%b r%b want=v0 r1", resp_valid, req_ready); end

    send(1'b0, 32'h1A4, 32'd0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL sl_load_accept got=0 want=1"); end
    checks++; if (memRead !== 1'b1 || memWrite !== 1'b0 || memAdress !== 32'd105)
      begin errors++; $display("FAIL sl_load_issue got=r%b w%b a%0d want=r1 w0 a105", memRead, memWrite, memAdress); end
    @(negedge clk);
    checks++; if (memRead !== 1'b0 || resp_valid !== 1'b0) begin errors++; $display("FAIL sl_load_capture got=r%b v%b want=r0 v0", memRead, resp_valid); end
    @(negedge clk);
    checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'd5 || resp_err !== 1'b0)
      begin errors++; $display("FAIL sl_load_resp got=v%b d%0d e%b want=v1 d5 e0", resp_valid, resp_rdata, resp_err); end
    @(negedge clk);
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL sl_load_done got=%b want=0", resp_valid); end
  endtask

  task automatic test_backpressure();
    bit ok;
    int w0;
    resp_ready = 1'b0;
    send(1'b0, 32'h1A4, 32'd0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_accept got=0 want=1"); end
    // A competing store is presented but must not be accepted while busy.
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h10; req_wdata = 32'h77;
    w0 = wr_cnt;
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'd5 || req_ready !== 1'b0)
        begin errors++; $display("FAIL bp_hold_%0d got=v%b d%0d r%b want=v1 d5 r0", i, resp_valid, resp_rdata, req_ready); end
      @(negedge clk);
    end
    resp_ready = 1'b1;
    req_valid  = 1'b0;
    @(negedge clk);
    checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL bp_release got=v%b r%b want=v0 r1", resp_valid, req_ready); end
    checks++; if (wr_cnt !== w0) begin errors++; $display("FAIL bp_no_write got=%0d want=%0d", wr_cnt, w0); end
  endtask

  task automatic test_misaligned();
    bit ok;
    int w0;
    w0 = wr_cnt;
    send(1'b1, 32'h1A6, 32'd9, ok);
    checks++; if (!ok) begin errors++; $display("FAIL mis_accept got=0 want=1"); end
    checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b1 || resp_rdata !== 32'd0)
      begin errors++; $display("FAIL mis_resp got=v%b e%b d%h want=v1 e1 d0", resp_valid, resp_err, resp_rdata); end
    checks++; if (memWrite !== 1'b0) begin errors++; $display("FAIL mis_strobe got=%b want=0", memWrite); end
    @(negedge clk);
    checks++; if (resp_valid !== 1'b0 || wr_cnt !== w0)
      begin errors++; $display("FAIL mis_done got=v%b writes=%0d want=v0 writes=%0d", resp_valid, wr_cnt, w0); end
  endtask

  task automatic test_bounds();
    bit ok;
    int r0;
    r0 = rd_cnt;
    send(1'b0, 32'h320, 32'd0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bnd_accept got=0 want=1"); end
`ifdef MEM_BOUNDS_CHECK_EN
    checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b1 || memRead !== 1'b0)
      begin errors++; $display("FAIL bnd_reject got=v%b e%b r%b want=v1 e1 r0", resp_valid, resp_err, memRead); end
    @(negedge clk);
    checks++; if (rd_cnt !== r0) begin errors++; $display("FAIL bnd_no_read got=%0d want=%0d", rd_cnt, r0); end
`else
    checks++; if (memRead !== 1'b1 || memAdress !== 32'd200)
      begin errors++; $display("FAIL bnd_pass got=r%b a%0d want=r1 a200", memRead, memAdress); end
    @(negedge clk);
    @(negedge clk);
    checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b0 || resp_rdata !== 32'd0)
      begin errors++; $display("FAIL bnd_resp got=v%b e%b d%h want=v1 e0 d0", resp_valid, resp_err, resp_rdata); end
    @(negedge clk);
    checks++; if (rd_cnt !== r0 + 1) begin errors++; $display("FAIL bnd_read_count got=%0d want=%0d", rd_cnt, r0 + 1); end
`endif
  endtask

  task automatic test_back_to_back();
    int n;
    int ov0;
    ov0 = overlap_cnt;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h1A4; req_wdata = 32'd0;
    n = 0;
    while (!req_ready && n < 10) begin @(negedge clk); n++; end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_load_ready got=%b want=1", req_ready); end
    @(posedge clk);
    @(negedge clk);
    // E+1: load in ISSUE; store now waits on the request port.
    req_write = 1'b1; req_addr = 32'h8; req_wdata = 32'h33;
    for (int i = 1; i <= 3; i++) begin
      checks++; if (req_ready !== 1'b0 || memWrite !== 1'b0)
        begin errors++; $display("FAIL b2b_busy_%0d got=r%b w%b want=r0 w0", i, req_ready, memWrite); end
      if (i == 3) begin
        checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'd5)
          begin errors++; $display("FAIL b2b_load_resp got=v%b d%0d want=v1 d5", resp_valid, resp_rdata); end
      end
      @(negedge clk);
    end
    checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0 || memWrite !== 1'b0)
      begin errors++; $display("FAIL b2b_idle got=r%b v%b w%b want=r1 v0 w0", req_ready, resp_valid, memWrite); end
    @(negedge clk);
    req_valid = 1'b0;
    checks++; if (memWrite !== 1'b1 || memRead !== 1'b0 || memAdress !== 32'd2 || memData !== 32'h33)
      begin errors++; $display("FAIL b2b_store_issue got=w%b r%b a%0d d%h want=w1 r0 a2 d33", memWrite, memRead, memAdress, memData); end
    @(negedge clk);
    checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b0 || resp_rdata !== 32'd0)
      begin errors++; $display("FAIL b2b_store_resp got=v%b e%b d%h want=v1 e0 d0", resp_valid, resp_err, resp_rdata); end
    @(negedge clk);
    checks++; if (overlap_cnt !== ov0) begin errors++; $display("FAIL b2b_overlap got=%0d want=%0d", overlap_cnt, ov0); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int w0;
    w0 = wr_cnt;
    send(1'b1, 32'h40, 32'hAB, ok);
    checks++; if (!ok || memWrite !== 1'b1) begin errors++; $display("FAIL rst_mid_issue got=ok%b w%b want=ok1 w1", ok, memWrite); end
    #1 reset = 1'b1;
    #1;
    checks++; if (memWrite !== 1'b0 || memAdress !== 32'd0 || memData !== 32'd0)
      begin errors++; $display("FAIL rst_mid_drop got=w%b a%h d%h want=w0 a0 d0", memWrite, memAdress, memData); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready got=%b want=1", req_ready); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_no_resp_%0d got=%b want=0", i, resp_valid); end
      @(negedge clk);
    end
    checks++; if (wr_cnt !== w0) begin errors++; $display("FAIL rst_mid_no_write got=%0d want=%0d", wr_cnt, w0); end
  endtask

  initial begin
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    resp_ready = 1'b1;
    test_reset();
    test_store_load();
    test_backpressure();
    test_misaligned();
    test_bounds();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
